mt_core_controller: RTL and testbench

Parametrised successor to the single-thread core controller: sequences the core through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE for up to THREADS independent thread contexts, each with its own PC, switching threads round-robin at every UPDATE. Sits between the fetcher, LSU, PC unit and register file inside a core. Adds a per-thread done mask, an LSU wait watchdog and a retired-instruction counter.

---
 rtl/mt_core_controller_pkg.sv | 35 +++
 rtl/mt_core_controller_rr_thread_picker.sv | 43 ++++
 rtl/mt_core_controller.sv | 146 ++++++++++++++
 tb/tb_mt_core_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mt_core_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mt_core_controller_pkg
// Brief    : Shared encodings for the multi-thread core controller.
// Revision : 1.0 - initial release
// ============================================================================
package mt_core_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } core_state_e;

  localparam logic [2:0] FETCHER_FETCHED = 3'd2;

  localparam logic [1:0] LSU_IDLE       = 2'd0;
  localparam logic [1:0] LSU_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_WAITING    = 2'd2;
  localparam logic [1:0] LSU_DONE       = 2'd3;

  localparam int RETIRED_W = 16;

  // The LSU has nothing outstanding for the active thread.
  function automatic logic lsu_settled(input logic [1:0] s);
    return (s == LSU_IDLE) || (s == LSU_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mt_core_controller_rr_thread_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_thread_picker
// Brief    : Round-robin pick of the next alive thread after cur_idx (wraps,
//            may return cur_idx itself).
// Revision : 1.0 - initial release
// ============================================================================
module rr_thread_picker #(
  parameter int THREADS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [THREADS-1:0] alive,
  input  logic [IDX_W-1:0]   cur_idx,
  output logic [IDX_W-1:0]   next_idx,
  output logic               any_alive
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;

  // Descending scan: the last hit is the lowest index in each half.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int j = THREADS - 1; j >= 0; j--) begin
      if (alive[j]) begin
        if (j > int'(cur_idx)) begin
          hi_idx   = IDX_W'(j);
          hi_found = 1'b1;
        end else begin
          lo_idx = IDX_W'(j);
        end
      end
    end
  end

  assign next_idx  = hi_found ? hi_idx : lo_idx;
  assign any_alive = |alive;

endmodule
`default_nettype wire

// File: rtl/mt_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : mt_core_controller
// Brief    : Multi-thread core sequencer with per-thread PCs, round-robin
//            switching at UPDATE, LSU watchdog and retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module mt_core_controller
  import mt_core_controller_pkg::*;
#(
  parameter int THREADS      = 4,
  parameter int PC_BITS      = 8,
  parameter int START_PC     = 0,
  parameter int WAIT_TIMEOUT = 255,
  localparam int IDX_W       = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [THREADS-1:0]   thread_mask,
  input  logic [2:0]           fetcher_state,
  input  logic [1:0]           lsu_state,
  input  logic                 decoded_ret,
  input  logic [PC_BITS-1:0]   next_pc,
  output logic [PC_BITS-1:0]   current_pc,
  output logic [IDX_W-1:0]     active_thread,
  output logic [2:0]           core_state,
  output logic [THREADS-1:0]   thread_done,
  output logic                 done,
  output logic                 timeout_err,
  output logic [RETIRED_W-1:0] instr_retired
);

  localparam int WD_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  core_state_e            state_q, state_d;
  logic [PC_BITS-1:0]     pc_q [THREADS];
  logic [PC_BITS-1:0]     pc_d [THREADS];
  logic [IDX_W-1:0]       active_q, active_d;
  logic [THREADS-1:0]     tdone_q, tdone_d;
  logic                   terr_q, terr_d;
  logic [RETIRED_W-1:0]   ret_q, ret_d;
  logic [WD_W-1:0]        wcnt_q, wcnt_d;

  logic [THREADS-1:0]     done_after;
  logic [IDX_W-1:0]       first_idx, next_idx;
  logic                   first_any, next_any;

  // Done mask as it will stand once the current UPDATE retires.
  assign done_after = tdone_q | (decoded_ret ? (THREADS'(1) << active_q) : '0);

  rr_thread_picker #(.THREADS(THREADS), .IDX_W(IDX_W)) u_first_pick (
    .alive     (thread_mask),
    .cur_idx   (IDX_W'(THREADS - 1)),
    .next_idx  (first_idx),
    .any_alive (first_any)
  );

  rr_thread_picker #(.THREADS(THREADS), .IDX_W(IDX_W)) u_next_pick (
    .alive     (~done_after),
    .cur_idx   (active_q),
    .next_idx  (next_idx),
    .any_alive (next_any)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    active_d = active_q;
    tdone_d  = tdone_q;
    terr_d   = terr_q;
    ret_d    = ret_q;
    wcnt_d   = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          for (int i = 0; i < THREADS; i++) pc_d[i] = PC_BITS'(START_PC);
          tdone_d  = ~thread_mask;
          terr_d   = 1'b0;
          ret_d    = '0;
          active_d = first_idx;
          state_d  = first_any ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) state_d = ST_DECODE;
      end
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lsu_settled(lsu_state)) begin
          state_d = ST_EXECUTE;
        end else if ((WAIT_TIMEOUT != 0) &&
                     ((32'(wcnt_q) + 32'd1) == 32'(WAIT_TIMEOUT))) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + WD_W'(1);
        end
      end
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE: begin
        pc_d[active_q] = next_pc;
        if (ret_q != '1) ret_d = ret_q + RETIRED_W'(1);
        tdone_d = done_after;
        if (!next_any) begin
          state_d = ST_DONE;
        end else begin
          active_d = next_idx;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < THREADS; i++) pc_q[i] <= '0;
      active_q <= '0;
      tdone_q  <= '0;
      terr_q   <= 1'b0;
      ret_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      active_q <= active_d;
      tdone_q  <= tdone_d;
      terr_q   <= terr_d;
      ret_q    <= ret_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign current_pc    = pc_q[active_q];
  assign active_thread = active_q;
  assign core_state    = state_q;
  assign thread_done   = tdone_q;
  assign done          = (state_q == ST_DONE);
  assign timeout_err   = terr_q;
  assign instr_retired = ret_q;

endmodule
`default_nettype wire

// File: tb/tb_mt_core_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mt_core_controller
// Brief    : Directed self-checking bench for mt_core_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mt_core_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_mask;
  logic [2:0]  fetcher_state;
  logic [1:0]  lsu_state;
  logic        decoded_ret;
  logic [7:0]  next_pc;
  logic [7:0]  current_pc;
  logic [1:0]  active_thread;
  logic [2:0]  core_state;
  logic [3:0]  thread_done;
  logic        done;
  logic        timeout_err;
  logic [15:0] instr_retired;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mt_core_controller #(
    .THREADS(4), .PC_BITS(8), .START_PC(16), .WAIT_TIMEOUT(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .thread_mask(thread_mask),
    .fetcher_state(fetcher_state), .lsu_state(lsu_state),
    .decoded_ret(decoded_ret), .next_pc(next_pc), .current_pc(current_pc),
    .active_thread(active_thread), .core_state(core_state),
    .thread_done(thread_done), .done(done), .timeout_err(timeout_err),
    .instr_retired(instr_retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the FETCH cycle, walks to UPDATE, then retires with npc/ret.
  task automatic run_instr(input int thr, input logic [7:0] pc,
                           input logic [7:0] npc, input logic ret);
    check("fetch_state", 32'(core_state), 32'd1);
    check("active", 32'(active_thread), 32'(thr));
    check("cur_pc", 32'(current_pc), 32'(pc));
    repeat (5) tick();
    check("update_state", 32'(core_state), 32'd6);
    next_pc     = npc;
    decoded_ret = ret;
    tick();
    decoded_ret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; thread_mask = 4'h0;
    fetcher_state = 3'd2; lsu_state = 2'd3; decoded_ret = 1'b0; next_pc = 8'h00;
    tick();
    check("rst_state", 32'(core_state), 32'd0);
    check("rst_pc", 32'(current_pc), 32'd0);
    check("rst_done", {28'd0, done, timeout_err, 2'd0} | 32'(thread_done), 32'd0);
    reset = 1'b1;
    tick();

    // Two threads, RET on second instruction of each.
    thread_mask = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(0, 8'h10, 8'h11, 1'b0);
    run_instr(2, 8'h10, 8'h11, 1'b0);
    run_instr(0, 8'h11, 8'h12, 1'b1);
    run_instr(2, 8'h11, 8'h12, 1'b1);
    check("k1_state", 32'(core_state), 32'd7);
    check("k1_done", 32'(done), 32'd1);
    check("k1_retired", 32'(instr_retired), 32'd4);
    check("k1_tdone", 32'(thread_done), 32'hF);

    // Empty mask goes straight to DONE with counters cleared.
    thread_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("m0_state", 32'(core_state), 32'd7);
    check("m0_done", 32'(done), 32'd1);
    check("m0_retired", 32'(instr_retired), 32'd0);
    check("m0_tdone", 32'(thread_done), 32'hF);

    // Watchdog: LSU stuck WAITING.
    thread_mask = 4'b0001; start = 1'b1; lsu_state = 2'd2;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("wd_enter", 32'(core_state), 32'd4);
    repeat (4) tick();
    check("wd_still", 32'(core_state), 32'd4);
    check("wd_noerr", 32'(timeout_err), 32'd0);
    tick();
    check("wd_state", 32'(core_state), 32'd7);
    check("wd_err", 32'(timeout_err), 32'd1);
    check("wd_tdone", 32'(thread_done), 32'hE);
    lsu_state = 2'd3;

    // PC wrap on a single thread.
    thread_mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    check("wr_errclr", 32'(timeout_err), 32'd0);
    run_instr(0, 8'h10, 8'hFF, 1'b0);
    run_instr(0, 8'hFF, 8'h00, 1'b1);
    check("wr_pc", 32'(current_pc), 32'd0);
    check("wr_state", 32'(core_state), 32'd7);
    check("wr_retired", 32'(instr_retired), 32'd2);

    // Asynchronous reset during WAIT of thread 2.
    thread_mask = 4'b0100; start = 1'b1; lsu_state = 2'd2;
    tick();
    start = 1'b0;
    check("ar_active", 32'(active_thread), 32'd2);
    repeat (3) tick();
    check("ar_wait", 32'(core_state), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("ar_state", 32'(core_state), 32'd0);
    check("ar_active0", 32'(active_thread), 32'd0);
    check("ar_pc", 32'(current_pc), 32'd0);
    check("ar_tdone", 32'(thread_done), 32'd0);
    check("ar_flags", {30'd0, done, timeout_err}, 32'd0);
    check("ar_retired", 32'(instr_retired), 32'd0);
    #1 reset = 1'b1;
    lsu_state = 2'd3;
    thread_mask = 4'b1000; start = 1'b1;
    tick();
    start = 1'b0;
    check("ar_t3", 32'(active_thread), 32'd3);
    check("ar_startpc", 32'(current_pc), 32'h10);
    check("ar_fetch", 32'(core_state), 32'd1);

    // start during EXECUTE is ignored.
    repeat (4) tick();
    check("ex_state", 32'(core_state), 32'd5);
    thread_mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    check("ex_ignored", 32'(core_state), 32'd6);
    check("ex_active", 32'(active_thread), 32'd3);
    next_pc = 8'h20; decoded_ret = 1'b1;
    tick();
    decoded_ret = 1'b0;
    check("ex_done", 32'(core_state), 32'd7);
    check("ex_retired", 32'(instr_retired), 32'd1);

    // Restart from DONE.
    thread_mask = 4'b0011; start = 1'b1; fetcher_state = 3'd0;
    tick();
    start = 1'b0;
    check("rs_fetch", 32'(core_state), 32'd1);
    check("rs_retired", 32'(instr_retired), 32'd0);
    check("rs_tdone", 32'(thread_done), 32'hC);
    check("rs_pc", 32'(current_pc), 32'h10);
    tick();
    check("rs_hold", 32'(core_state), 32'd1);
    fetcher_state = 3'd2;
    tick();
    check("rs_decode", 32'(core_state), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
